// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the VGA snake: idle/play/pause/over, move tick,
// button edge detection, collision, BCD score with high score and levels.
module snake_game_ctrl #(
  parameter int CNT_W            = 23,
  parameter int BASE_PERIOD      = 5_000_000,
  parameter int PERIOD_STEP      = 500_000,
  parameter int MIN_PERIOD       = 1_666_666,
  parameter int APPLES_PER_LEVEL = 5,
  parameter int MAX_LEVEL        = 15,
  parameter int DIGITS           = 2
) (
  input  logic                  clk_pix,
  input  logic                  reset_n,
  input  logic                  start_n,
  input  logic                  pause_n,
  input  logic                  eat_evt,
  input  logic                  self_hit,
  input  logic                  wall_hit,
  output logic                  tick_run,
  output logic                  game_reset,
  output logic [1:0]            state,
  output logic [3:0]            level,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hiscore_bcd
);

  localparam int SW   = 4 * DIGITS;
  localparam int AW   = (APPLES_PER_LEVEL > 1) ?
                        $clog2(APPLES_PER_LEVEL) : 1;
  localparam int PW   = CNT_W + 4;
  localparam int SPAN = (BASE_PERIOD > MIN_PERIOD) ?
                        BASE_PERIOD - MIN_PERIOD : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  logic [1:0]       start_sync_q;
  logic [1:0]       pause_sync_q;
  logic             start_prev_q;
  logic             pause_prev_q;
  logic             start_press;
  logic             pause_press;

  state_e           state_q;
  state_e           state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period;
  logic [PW-1:0]    dec;
  logic             tick_due;

  logic [3:0]       level_q;
  logic [3:0]       level_d;
  logic [AW-1:0]    apple_q;
  logic [AW-1:0]    apple_d;
  logic             apple_wrap;

  logic [SW-1:0]    score_q;
  logic [SW-1:0]    score_d;
  logic [SW-1:0]    score_inc;
  logic [SW-1:0]    hisc_q;
  logic [SW-1:0]    hisc_d;
  logic             carry;

  logic             gr_q;
  logic             gr_d;
  logic             launch;
  logic             play_eat;
  logic             enter_over;

  // Buttons: 2-flop sync plus previous value; a press is a falling edge.
  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      start_sync_q <= 2'b11;
      pause_sync_q <= 2'b11;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      start_sync_q <= {start_sync_q[0], start_n};
      pause_sync_q <= {pause_sync_q[0], pause_n};
      start_prev_q <= start_sync_q[1];
      pause_prev_q <= pause_sync_q[1];
    end
  end

  assign start_press = start_prev_q & ~start_sync_q[1];
  assign pause_press = pause_prev_q & ~pause_sync_q[1];

  // Compare before subtracting so the period never wraps below the clamp.
  always_comb begin
    dec = PW'(level_q) * PW'(PERIOD_STEP);
    if (dec >= PW'(SPAN)) begin
      period = CNT_W'(MIN_PERIOD);
    end else begin
      period = CNT_W'(BASE_PERIOD) - dec[CNT_W-1:0];
    end
  end

  assign tick_due = (cnt_q >= period - CNT_W'(1));

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_press) state_d = S_PLAY;
      S_PLAY: begin
        if (tick_due && (self_hit || wall_hit)) begin
          state_d = S_OVER;
        end else if (pause_press) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: if (pause_press) state_d = S_PLAY;
      S_OVER:  if (start_press) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_run   = (state_q == S_PLAY) && tick_due;
    launch     = start_press &&
                 ((state_q == S_IDLE) || (state_q == S_OVER));
    play_eat   = eat_evt && (state_q == S_PLAY);
    enter_over = (state_q == S_PLAY) && (state_d == S_OVER);
  end

  // BCD +1 with ripple carry; all nines stays put.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) begin
      score_inc = score_q;
    end
  end

  assign apple_wrap = (apple_q == AW'(APPLES_PER_LEVEL - 1));

  always_comb begin
    cnt_d   = cnt_q;
    score_d = score_q;
    apple_d = apple_q;
    level_d = level_q;
    hisc_d  = hisc_q;
    gr_d    = launch;
    if (launch) begin
      cnt_d   = '0;
      score_d = '0;
      apple_d = '0;
      level_d = '0;
    end else begin
      if (state_q == S_PLAY) begin
        cnt_d = tick_due ? '0 : cnt_q + CNT_W'(1);
      end
      if (play_eat) begin
        score_d = score_inc;
        apple_d = apple_wrap ? '0 : apple_q + AW'(1);
        if (apple_wrap && (level_q != 4'(MAX_LEVEL))) begin
          level_d = level_q + 4'd1;
        end
      end
    end
    if (enter_over && (score_d > hisc_q)) begin
      hisc_d = score_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      score_q <= '0;
      apple_q <= '0;
      level_q <= '0;
      hisc_q  <= '0;
      gr_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      score_q <= score_d;
      apple_q <= apple_d;
      level_q <= level_d;
      hisc_q  <= hisc_d;
      gr_q    <= gr_d;
    end
  end

  assign game_reset  = gr_q;
  assign state       = state_q;
  assign level       = level_q;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hisc_q;

endmodule
